// File: rtl/dfr_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dfr_bram_port_arbiter
// Purpose  : Shares a single BRAM port among NUM_REQ requesters. Round-robin
//            arbitration with an optional per-requester burst lock. Memory
//            commands are issued from registers. Read data is steered back to
//            the issuing requester after a fixed READ_LATENCY.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req/lock/wen      - per-requester request, burst lock, write enable
//            addr/wdata        - packed per-requester address / write data
//            gnt               - one-hot combinational grant
//            rvalid/rdata      - one-hot read strobe and returned data
//            mem_en/we/addr/din- registered BRAM command
//            mem_dout          - BRAM read data
//            busy              - any request pending or any command in flight
// Revision : 1.0 - initial release
// ============================================================================
module dfr_bram_port_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            wen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_din,
    input  logic [DATA_WIDTH-1:0]         mem_dout,
    output logic                          busy
);

    localparam int                   c_IDX_W    = $clog2(NUM_REQ);
    localparam int                   c_SUM_W    = c_IDX_W + 1;
    localparam logic [c_SUM_W-1:0]   c_NUM_REQ  = c_SUM_W'(NUM_REQ);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   c_ONE      = NUM_REQ'(1);

    // Unpacked views of the per-requester buses
    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [c_IDX_W-1:0]    r_ptr;
    logic [c_IDX_W-1:0]    r_owner;
    logic                  r_owner_vld;
    logic                  r_rst_d;
    logic [READ_LATENCY:0] r_pipe_vld;
    logic [c_IDX_W-1:0]    r_pipe_id [READ_LATENCY+1];

    logic                  w_block;
    logic                  w_owner_hold;
    logic                  w_accept;
    logic                  w_rr_found;
    logic [c_IDX_W-1:0]    w_rr_idx;
    logic [c_IDX_W-1:0]    w_gnt_idx;
    logic [c_SUM_W-1:0]    w_cand_sum;
    logic [c_IDX_W-1:0]    w_cand;

    // Grants are suppressed during reset and for one cycle after it releases
    assign w_block      = rst | r_rst_d;
    assign w_owner_hold = r_owner_vld & req[r_owner] & lock[r_owner];

    // Round-robin search: first requester at or after r_ptr, wrapping
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand_sum = '0;
        w_cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand_sum = {1'b0, r_ptr} + c_SUM_W'(i);
            if (w_cand_sum >= c_NUM_REQ) begin
                w_cand_sum = w_cand_sum - c_NUM_REQ;
            end
            w_cand = w_cand_sum[c_IDX_W-1:0];
            if (!w_rr_found && req[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    // A holding lock owner overrides round-robin; a released owner falls
    // back to round-robin in the same cycle.
    always_comb begin
        w_gnt_idx = w_rr_idx;
        w_accept  = w_rr_found;
        if (w_owner_hold) begin
            w_gnt_idx = r_owner;
            w_accept  = 1'b1;
        end
        if (w_block) begin
            w_accept = 1'b0;
        end
    end

    assign gnt = w_accept ? (c_ONE << w_gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_d     <= 1'b1;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            r_pipe_vld  <= '0;
        end else begin
            r_rst_d <= 1'b0;
            mem_en  <= w_accept;
            mem_we  <= w_accept & wen[w_gnt_idx];
            // Ownership survives only while the owner keeps being accepted
            // with lock asserted; anything else releases it.
            r_owner_vld <= w_accept & lock[w_gnt_idx];
            if (w_accept) begin
                mem_addr <= w_addr_arr[w_gnt_idx];
                mem_din  <= w_wdata_arr[w_gnt_idx];
                r_owner  <= w_gnt_idx;
                r_ptr    <= (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + c_IDX_W'(1);
            end
            // Stage 0 lines up with mem_en; stage READ_LATENCY with mem_dout
            r_pipe_vld <= {r_pipe_vld[READ_LATENCY-1:0], w_accept & ~wen[w_gnt_idx]};
        end
    end

    // Requester ids ride alongside the valid bits; no reset needed
    always_ff @(posedge clk) begin
        r_pipe_id[0] <= w_gnt_idx;
        for (int i = 1; i <= READ_LATENCY; i++) begin
            r_pipe_id[i] <= r_pipe_id[i-1];
        end
    end

    assign rvalid = (r_pipe_vld[READ_LATENCY] & ~rst) ? (c_ONE << r_pipe_id[READ_LATENCY]) : '0;
    assign rdata  = mem_dout;
    assign busy   = ~w_block & ((|req) | mem_en | (|r_pipe_vld));

`ifndef SYNTHESIS
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_has_req: assert property (@(posedge clk) disable iff (rst) ((gnt & ~req) == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dfr_bram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dfr_bram_port_arbiter
// Purpose  : Self-checking bench for dfr_bram_port_arbiter. Directed
//            scenarios followed by random traffic, all compared against a
//            cycle-level reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dfr_bram_port_arbiter;

    localparam int N     = 3;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, wen;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, mem_din, mem_dout;
    logic            mem_en, mem_we, busy;
    logic [AW-1:0]   mem_addr;

    always #5 clk = ~clk;

    dfr_bram_port_arbiter #(
        .NUM_REQ      (N),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .wen      (wen),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    // ---------------- BRAM model (READ_LATENCY register stages) -----------
    function automatic logic [DW-1:0] f_init_word(input int i);
        if (i == 'h10) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    logic [DW-1:0] bram  [DEPTH];
    logic [DW-1:0] dpipe [RL];
    bit            loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= f_init_word(i);
            loaded <= 1'b1;
        end else if (mem_en && mem_we) begin
            bram[mem_addr] <= mem_din;
        end
        if (mem_en && !mem_we) dpipe[0] <= bram[mem_addr];
        for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mem_dout = dpipe[RL-1];

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] shadow [DEPTH];
    int            m_ptr     = 0;
    int            m_owner   = -1;
    bit            m_blocked = 1'b1;
    bit            e_en      = 1'b0;
    bit            e_zero    = 1'b1;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [N-1:0]  m_last    = '0;

    // directed extra expectations for the current cycle
    bit            d_gnt_en = 0, d_rv_en = 0, d_busy_en = 0;
    logic [N-1:0]  d_gnt, d_rv;
    logic [DW-1:0] d_rd;
    bit            d_busy;

    task automatic model_cycle();
        int            k;
        bit            hold;
        bit            eb;
        logic [N-1:0]  eg, erv;
        logic [DW-1:0] erd;
        rd_t           r;
        k = -1; eg = '0; erv = '0; erd = '0; hold = 1'b0;
        if (!rst && !m_blocked) begin
            if (m_owner >= 0) hold = req[m_owner] && lock[m_owner];
            if (hold) begin
                k = m_owner;
            end else begin
                m_owner = -1;
                for (int i = 0; i < N; i++)
                    if (k < 0 && req[(m_ptr + i) % N]) k = (m_ptr + i) % N;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        eb = !rst && !m_blocked && ((|req) || e_en || rq.size() != 0);
        if (rq.size() != 0 && rq[0].due == cyc) begin
            if (!rst) begin
                erv[rq[0].id] = 1'b1;
                erd = rq[0].data;
            end
            void'(rq.pop_front());
        end

        check("gnt", gnt, eg);
        check("rvalid", rvalid, erv);
        if (erv != '0) check("rdata", rdata, erd);
        check("busy", busy, eb);
        check("mem_en", mem_en, e_en);
        if (e_en) begin
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_din", mem_din, e_din);
        end
        if (e_zero) begin
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_din", mem_din, 0);
        end
        if (d_gnt_en)  check("dir_gnt", gnt, d_gnt);
        if (d_rv_en) begin
            check("dir_rvalid", rvalid, d_rv);
            check("dir_rdata", rdata, d_rd);
        end
        if (d_busy_en) check("dir_busy", busy, d_busy);
        d_gnt_en = 0; d_rv_en = 0; d_busy_en = 0;

        // advance model state to the next cycle
        m_blocked = rst;
        e_zero    = rst;
        if (rst) begin
            m_ptr   = 0;
            m_owner = -1;
            rq.delete();
            e_en    = 1'b0;
            m_last  = '0;
        end else begin
            e_en   = (k >= 0);
            m_last = eg;
            if (k >= 0) begin
                m_ptr  = (k + 1) % N;
                if (lock[k]) m_owner = k;
                e_we   = wen[k];
                e_addr = addr[k*AW +: AW];
                e_din  = wdata[k*DW +: DW];
                if (wen[k]) begin
                    shadow[e_addr] = e_din;
                end else begin
                    r.due  = cyc + 1 + RL;
                    r.id   = k;
                    r.data = shadow[e_addr];
                    rq.push_back(r);
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rst_left;
        for (int i = 0; i < DEPTH; i++) shadow[i] = f_init_word(i);
        rst = 1'b1; req = '0; lock = '0; wen = '0; addr = '0; wdata = '0;
        rst_left = 0;
        @(posedge clk);
        #1;
        repeat (2) step();

        // First cycle after reset: nothing granted even with requests up
        rst = 1'b0; req = 3'b111;
        d_gnt_en = 1; d_gnt = '0; d_busy_en = 1; d_busy = 1'b0;
        step();

        // Round-robin with all three requesting
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < N; j++) set_slot(j, AW'(32'h40 + i*4 + j), '0);
            d_gnt_en = 1; d_gnt = N'(1 << (i % 3));
            step();
        end

        // Read latency: requester 2 reads 0x010
        req = 3'b100; set_slot(2, 12'h010, '0);
        d_gnt_en = 1; d_gnt = 3'b100;
        step();
        req = '0;
        step();
        step();
        d_rv_en = 1; d_rv = 3'b100; d_rd = 32'hDEAD_BEEF;
        step();

        // Lock burst by requester 1
        req = 3'b010; lock = 3'b010;
        d_gnt_en = 1; d_gnt = 3'b010;
        step();
        req = 3'b111;
        repeat (7) begin
            d_gnt_en = 1; d_gnt = 3'b010;
            step();
        end
        lock = '0;
        d_gnt_en = 1; d_gnt = 3'b100;
        step();
        d_gnt_en = 1; d_gnt = 3'b001;
        step();
        req = '0;
        repeat (4) step();

        // Write then read same address from different requesters
        req = 3'b001; wen = 3'b001; set_slot(0, 12'h005, 32'h1234_5678);
        d_gnt_en = 1; d_gnt = 3'b001;
        step();
        req = 3'b010; wen = '0; set_slot(1, 12'h005, '0);
        d_gnt_en = 1; d_gnt = 3'b010;
        step();
        req = '0;
        step();
        step();
        d_rv_en = 1; d_rv = 3'b010; d_rd = 32'h1234_5678;
        step();

        // Abandoned pulse from requester 2 while requester 0 holds the lock
        set_slot(0, 12'h0A0, '0); set_slot(2, 12'h0F0, '0);
        req = 3'b001; lock = 3'b001;
        step();
        req = 3'b101;
        d_gnt_en = 1; d_gnt = 3'b001;
        step();
        req = 3'b001;
        d_gnt_en = 1; d_gnt = 3'b001;
        step();
        req = '0; lock = '0;
        for (int i = 1; i <= RL + 2; i++) begin
            d_busy_en = 1; d_busy = (i <= RL + 1);
            step();
        end

        // Reset while a read from requester 1 is in flight
        req = 3'b010;
        step();
        req = '0; rst = 1'b1;
        step();
        step();
        rst = 1'b0; req = 3'b110;
        d_gnt_en = 1; d_gnt = '0;
        step();
        d_gnt_en = 1; d_gnt = 3'b010;
        step();
        req = '0;
        repeat (5) step();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = 2;
            rst = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            for (int i = 0; i < N; i++) begin
                if (req[i] && !m_last[i]) begin
                    if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                end else begin
                    req[i] = ($urandom_range(0, 1) == 1);
                end
                if (m_last[i] && lock[i]) lock[i] = ($urandom_range(0, 4) != 0);
                else                      lock[i] = ($urandom_range(0, 3) == 0);
                wen[i] = ($urandom_range(0, 1) == 1);
                set_slot(i, AW'($urandom_range(0, 31)), $urandom);
            end
            step();
        end
        rst = 1'b0; req = '0; lock = '0;
        repeat (RL + 3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
